// File: rtl/send_pkg.sv
// -----------------------------------------------------------------------------
// send_pkg
// Shared definitions for the frame-send scheduler and its pacing helpers.
//   send_state_t        : scheduler state encoding
//   AUX_*_BIT           : bit positions inside the aux tag
//   ACK_TIMEOUT_DEFAULT : default number of cycles to wait for busy after a start
//   copies_of()         : maps a redundancy setting to the number of copies sent
// -----------------------------------------------------------------------------
package send_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GAP       = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        NEXT      = 3'd5
    } send_state_t;

    localparam int AUX_LAST_BIT    = 0;
    localparam int AUX_AT_MAX_BIT  = 1;
    localparam int AUX_TIMEOUT_BIT = 2;

    localparam int ACK_TIMEOUT_DEFAULT = 15;

    // A redundancy of zero would mean "send nothing", which is never useful;
    // it is treated as a single copy.
    function automatic int unsigned copies_of(input int unsigned red);
        return (red == 0) ? 1 : red;
    endfunction

endpackage

// File: rtl/gap_timer.sv
// -----------------------------------------------------------------------------
// gap_timer
// Inter-frame gap pacing counter. Latches a gap length, counts up from zero
// while running and stops at the latched length, holding there until cleared.
//
// Ports:
//   i_clk    : clock, rising edge
//   i_rstn   : asynchronous active-low reset
//   i_load   : latch i_limit as the new gap length and restart the count at 0
//   i_limit  : gap length to latch on i_load
//   i_clear  : restart the count at 0, keeping the latched length
//   i_run    : advance the count by one (never past the latched length)
//   o_done   : count has reached the latched length
// -----------------------------------------------------------------------------
module gap_timer #(
    parameter int CNT_W = 28
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_limit,
    input  logic             i_clear,
    input  logic             i_run,
    output logic             o_done
);

    logic [CNT_W-1:0] r_limit;
    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count == r_limit);
    assign o_done     = w_at_limit;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_limit <= '0;
            r_count <= '0;
        end else begin
            if (i_load) begin
                r_limit <= i_limit;
                r_count <= '0;
            end else if (i_clear) begin
                r_count <= '0;
            end else if (i_run && !w_at_limit) begin
                // Holding at the limit lets the caller wait out a busy
                // receiver without the count running past the gap.
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/send_scheduler.sv
// -----------------------------------------------------------------------------
// send_scheduler
// Issues start pulses to the byte-data frame generator. Every segment is sent
// as a burst of `redundancy` copies, each copy preceded by a programmable idle
// gap and tagged with its copy index (txid) and segment number. After each
// start the builder must acknowledge by raising busy within ACK_TIMEOUT
// cycles; otherwise the copy is counted as dropped and the burst moves on.
//
// Ports:
//   clk125MHz     in   system clock, rising edge
//   rstn          in   asynchronous active-low reset
//   enable        in   allows a new burst to start from IDLE
//   gap_count     in   idle cycles before each copy (latched per burst)
//   redundancy    in   copies per segment, 0 treated as 1 (latched per burst)
//   segment_max   in   last segment number before wrap (latched per burst)
//   busy          in   frame builder is transmitting
//   start_sending out  one-cycle start pulse
//   txid          out  copy index within the burst
//   segment_num   out  segment currently being sent
//   aux           out  [0] last copy, [1] segment at max, [2] sticky timeout
//   drop_pulse    out  one-cycle pulse on an acknowledge timeout
//
// Build option SEND_SCHED_STATS_EN adds:
//   frames_sent   out  saturating count of issued starts
//   drops         out  saturating count of acknowledge timeouts
// -----------------------------------------------------------------------------
module send_scheduler
    import send_pkg::*;
#(
    parameter int CNT_W       = 28,
    parameter int SEG_W       = 16,
    parameter int ID_W        = 8,
    parameter int RED_W       = 4,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic             clk125MHz,
    input  logic             rstn,
    input  logic             enable,
    input  logic [CNT_W-1:0] gap_count,
    input  logic [RED_W-1:0] redundancy,
    input  logic [SEG_W-1:0] segment_max,
    input  logic             busy,
    output logic             start_sending,
    output logic [ID_W-1:0]  txid,
    output logic [SEG_W-1:0] segment_num,
    output logic [ID_W-1:0]  aux,
    output logic             drop_pulse
`ifdef SEND_SCHED_STATS_EN
    ,
    output logic [31:0]      frames_sent,
    output logic [15:0]      drops
`endif
);

    // The acknowledge timer only ever counts up to ACK_TIMEOUT-1.
    localparam int TMR_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    send_state_t      r_state;
    logic [RED_W-1:0] r_copy;
    logic [RED_W-1:0] r_red;
    logic [SEG_W-1:0] r_seg_max;
    logic [SEG_W-1:0] r_seg;
    logic [TMR_W-1:0] r_ack_tmr;
    logic             r_start;
    logic [ID_W-1:0]  r_txid;
    logic             r_aux_last;
    logic             r_aux_at_max;
    logic             r_aux_timeout;
    logic             r_drop;

    logic             w_burst_go;
    logic             w_gap_done;
    logic             w_is_last;
    logic             w_ack_expired;
    logic [ID_W-1:0]  w_aux;

    assign w_burst_go    = (r_state == IDLE) && enable && !busy;
    assign w_is_last     = (r_copy == (r_red - RED_W'(1)));
    assign w_ack_expired = (r_ack_tmr == TMR_W'(ACK_TIMEOUT - 1));

    // The gap length is latched together with the other burst settings, so a
    // gap_count change mid-burst only takes effect on the next burst.
    gap_timer #(
        .CNT_W   (CNT_W)
    ) u_gap_timer (
        .i_clk   (clk125MHz),
        .i_rstn  (rstn),
        .i_load  (w_burst_go),
        .i_limit (gap_count),
        .i_clear (r_state == NEXT),
        .i_run   (r_state == GAP),
        .o_done  (w_gap_done)
    );

    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_copy        <= '0;
            r_red         <= '0;
            r_seg_max     <= '0;
            r_seg         <= '0;
            r_ack_tmr     <= '0;
            r_start       <= 1'b0;
            r_txid        <= '0;
            r_aux_last    <= 1'b0;
            r_aux_at_max  <= 1'b0;
            r_aux_timeout <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            // Pulses default low; they are raised only on the transition
            // into the state they belong to.
            r_start <= 1'b0;
            r_drop  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_burst_go) begin
                        r_red     <= RED_W'(copies_of(32'(redundancy)));
                        r_seg_max <= segment_max;
                        r_copy    <= '0;
                        r_state   <= GAP;
                    end
                end

                GAP: begin
                    if (w_gap_done && !busy) begin
                        r_start      <= 1'b1;
                        r_txid       <= ID_W'(r_copy);
                        r_aux_last   <= w_is_last;
                        r_aux_at_max <= (r_seg == r_seg_max);
                        r_state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_ack_tmr <= '0;
                    r_state   <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (busy) begin
                        r_state <= WAIT_DONE;
                    end else if (w_ack_expired) begin
                        // The pulse lands exactly ACK_TIMEOUT+1 cycles after
                        // the start pulse, in the NEXT cycle.
                        r_drop        <= 1'b1;
                        r_aux_timeout <= 1'b1;
                        r_state       <= NEXT;
                    end else begin
                        r_ack_tmr <= r_ack_tmr + TMR_W'(1);
                    end
                end

                WAIT_DONE: begin
                    if (!busy) begin
                        r_state <= NEXT;
                    end
                end

                NEXT: begin
                    r_copy <= r_copy + RED_W'(1);
                    if (w_is_last) begin
                        r_seg   <= (r_seg == r_seg_max) ? '0 : r_seg + SEG_W'(1);
                        r_state <= IDLE;
                    end else begin
                        r_state <= GAP;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_aux                  = '0;
        w_aux[AUX_LAST_BIT]    = r_aux_last;
        w_aux[AUX_AT_MAX_BIT]  = r_aux_at_max;
        w_aux[AUX_TIMEOUT_BIT] = r_aux_timeout;
    end

    assign start_sending = r_start;
    assign txid          = r_txid;
    assign segment_num   = r_seg;
    assign aux           = w_aux;
    assign drop_pulse    = r_drop;

`ifdef SEND_SCHED_STATS_EN
    logic [31:0] r_frames_sent;
    logic [15:0] r_drops;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    // r_start is high for exactly the ISSUE cycle and r_drop for exactly one
    // cycle per timeout, so each counts one event per pulse.
    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            r_frames_sent <= '0;
            r_drops       <= '0;
        end else begin
            if (r_start) begin
                r_frames_sent <= sat_inc32(r_frames_sent);
            end
            if (r_drop) begin
                r_drops <= sat_inc16(r_drops);
            end
        end
    end

    assign frames_sent = r_frames_sent;
    assign drops       = r_drops;
`endif

endmodule

// File: tb/tb_send_scheduler.sv
// -----------------------------------------------------------------------------
// tb_send_scheduler
// Directed bench for send_scheduler. A behavioural burst model predicts the
// outputs cycle by cycle; a log of every start/drop is also compared against
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_send_scheduler;

    logic        clk125MHz;
    logic        rstn;
    logic        enable;
    logic [27:0] gap_count;
    logic [3:0]  redundancy;
    logic [15:0] segment_max;
    logic        busy;
    logic        start_sending;
    logic [7:0]  txid;
    logic [15:0] segment_num;
    logic [7:0]  aux;
    logic        drop_pulse;
`ifdef SEND_SCHED_STATS_EN
    logic [31:0] w_frames_sent;
    logic [15:0] w_drops;
`endif

    send_scheduler dut (
        .clk125MHz     (clk125MHz),
        .rstn          (rstn),
        .enable        (enable),
        .gap_count     (gap_count),
        .redundancy    (redundancy),
        .segment_max   (segment_max),
        .busy          (busy),
        .start_sending (start_sending),
        .txid          (txid),
        .segment_num   (segment_num),
        .aux           (aux),
        .drop_pulse    (drop_pulse)
`ifdef SEND_SCHED_STATS_EN
        ,
        .frames_sent   (w_frames_sent),
        .drops         (w_drops)
`endif
    );

    localparam int ACK_TO = 15;

    int checks = 0;
    int errors = 0;
    int resp_mode = 3;   // 0: busy low, 1: 5-cycle ack pulse, 2: busy high, 3: busy low
    bit model_on = 0;

    int n_starts = 0;
    int n_drops  = 0;
    int cyc      = 0;
    int log_txid[$];
    int log_seg[$];
    int log_aux[$];
    int log_cyc[$];
    int drop_cyc[$];

    logic        exp_start;
    logic [7:0]  exp_txid;
    logic [15:0] exp_seg;
    logic [7:0]  exp_aux;
    logic        exp_drop;

    initial begin
        clk125MHz = 1'b0;
        forever #4 clk125MHz = ~clk125MHz;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -1;
        return q[i];
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk125MHz);
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int t = 0;
        while (n_starts < target && t < budget) begin
            @(negedge clk125MHz);
            t++;
        end
        chk(name, (n_starts >= target), 1);
    endtask

    task automatic wait_drops(input int target, input int budget, input string name);
        int t = 0;
        while (n_drops < target && t < budget) begin
            @(negedge clk125MHz);
            t++;
        end
        chk(name, (n_drops >= target), 1);
    endtask

    // Busy responder: models the frame builder's acknowledge behaviour.
    initial begin
        int rc = 0;
        busy = 1'b0;
        forever begin
            @(negedge clk125MHz);
            case (resp_mode)
                1: begin
                    if (rc > 0) rc--;
                    busy = (rc != 0);
                    if (start_sending === 1'b1) rc = 6;
                end
                2: begin
                    rc   = 0;
                    busy = 1'b1;
                end
                default: begin
                    rc   = 0;
                    busy = 1'b0;
                end
            endcase
        end
    end

    // Event log of starts and drops, stamped with a cycle index.
    initial begin
        forever begin
            @(negedge clk125MHz);
            cyc++;
            if (start_sending === 1'b1) begin
                log_txid.push_back(int'(txid));
                log_seg.push_back(int'(segment_num));
                log_aux.push_back(int'(aux));
                log_cyc.push_back(cyc);
                n_starts++;
            end
            if (drop_pulse === 1'b1) begin
                drop_cyc.push_back(cyc);
                n_drops++;
            end
        end
    end

    // Burst model: walks through a burst as "wait for permission, then per
    // copy: gap, start, acknowledge or time out", sampling inputs on each
    // rising edge and publishing what the outputs must be after that edge.
    initial begin
        int g, r, m, n, k;
        bit acked, expired;
        exp_start = 1'b0;
        exp_txid  = '0;
        exp_seg   = '0;
        exp_aux   = '0;
        exp_drop  = 1'b0;
        wait (rstn === 1'b1);
        forever begin
            do @(posedge clk125MHz); while (!(enable && !busy));
            g = int'(gap_count);
            r = (redundancy == 0) ? 1 : int'(redundancy);
            m = int'(segment_max);
            for (int c = 0; c < r; c++) begin
                n = 0;
                do begin
                    @(posedge clk125MHz);
                    n++;
                end while (!(n >= g + 1 && !busy));
                exp_start  = 1'b1;
                exp_txid   = 8'(c);
                exp_aux[0] = (c == r - 1);
                exp_aux[1] = (int'(exp_seg) == m);
                @(posedge clk125MHz);
                exp_start = 1'b0;
                k = 0;
                acked = 0;
                expired = 0;
                while (!acked && !expired) begin
                    @(posedge clk125MHz);
                    k++;
                    if (busy) acked = 1;
                    else if (k == ACK_TO) expired = 1;
                end
                if (acked) begin
                    do @(posedge clk125MHz); while (busy);
                end else begin
                    exp_drop   = 1'b1;
                    exp_aux[2] = 1'b1;
                end
                @(posedge clk125MHz);
                exp_drop = 1'b0;
                if (c == r - 1) exp_seg = (int'(exp_seg) == m) ? 16'd0 : exp_seg + 16'd1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk125MHz);
            if (model_on) begin
                checks++;
                if ({start_sending, txid, segment_num, aux, drop_pulse} !==
                    {exp_start, exp_txid, exp_seg, exp_aux, exp_drop}) begin
                    errors++;
                    $display("FAIL cycle_compare cyc=%0d actual start=%0b txid=%0d seg=%0d aux=%0h drop=%0b required start=%0b txid=%0d seg=%0d aux=%0h drop=%0b",
                             cyc, start_sending, txid, segment_num, aux, drop_pulse,
                             exp_start, exp_txid, exp_seg, exp_aux, exp_drop);
                end
            end
        end
    end

    initial begin
        #(8 * 20000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a_seg[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0};
        rstn        = 1'b0;
        enable      = 1'b0;
        gap_count   = 28'd4;
        redundancy  = 4'd3;
        segment_max = 16'd2;
        resp_mode   = 1;
        idle(3);

        chk("rst_start", start_sending, 0);
        chk("rst_txid",  txid, 0);
        chk("rst_seg",   segment_num, 0);
        chk("rst_aux",   aux, 0);
        chk("rst_drop",  drop_pulse, 0);

        rstn     = 1'b1;
        model_on = 1;

        // A: gap 4, three copies, segment wraps after 2; enable drops at txid 1
        enable = 1'b1;
        wait_starts(11, 500, "A_reach11");
        enable = 1'b0;
        wait_starts(12, 100, "A_reach12");
        idle(40);
        chk("A_count", n_starts, 12);
        for (int i = 0; i < 12; i++) begin
            chk("A_txid", qget(log_txid, i), i % 3);
            chk("A_seg",  qget(log_seg, i), a_seg[i]);
            chk("A_aux",  qget(log_aux, i), ((i % 3 == 2) ? 1 : 0) + ((a_seg[i] == 2) ? 2 : 0));
        end
        chk("A_space", qget(log_cyc, 1) - qget(log_cyc, 0), 13);
        chk("A_seg_end", segment_num, 1);

        // B: redundancy 0 gives a single, last copy
        redundancy = 4'd0;
        gap_count  = 28'd2;
        enable     = 1'b1;
        wait_starts(13, 100, "B_reach13");
        enable = 1'b0;
        idle(30);
        chk("B_count", n_starts, 13);
        chk("B_txid", qget(log_txid, 12), 0);
        chk("B_aux",  qget(log_aux, 12), 1);
        chk("B_seg",  qget(log_seg, 12), 1);

        // C: no acknowledge; both copies time out, aux[2] becomes sticky
        resp_mode  = 0;
        redundancy = 4'd2;
        gap_count  = 28'd1;
        enable     = 1'b1;
        wait_starts(14, 100, "C_reach14");
        enable = 1'b0;
        wait_starts(15, 100, "C_reach15");
        wait_drops(2, 100, "C_drops");
        idle(30);
        chk("C_drop_delay", qget(drop_cyc, 0) - qget(log_cyc, 13), 16);
        chk("C_space", qget(log_cyc, 14) - qget(log_cyc, 13), 19);
        chk("C_aux0", qget(log_aux, 13), 2);
        chk("C_aux1", qget(log_aux, 14), 7);
        chk("C_txid1", qget(log_txid, 14), 1);
        chk("C_sticky", aux[2], 1);
        chk("C_seg_wrap", segment_num, 0);
        chk("C_ndrops", n_drops, 2);

        // D: gap change mid-burst applies only to the next burst
        resp_mode  = 1;
        redundancy = 4'd3;
        gap_count  = 28'd4;
        enable     = 1'b1;
        wait_starts(16, 100, "D_reach16");
        gap_count = 28'd100;
        wait_starts(19, 400, "D_reach19");
        enable = 1'b0;
        wait_starts(21, 400, "D_reach21");
        idle(30);
        chk("D_space_a", qget(log_cyc, 16) - qget(log_cyc, 15), 13);
        chk("D_space_b", qget(log_cyc, 17) - qget(log_cyc, 16), 13);
        chk("D_space_c", qget(log_cyc, 18) - qget(log_cyc, 17), 110);
        chk("D_space_d", qget(log_cyc, 19) - qget(log_cyc, 18), 109);
        chk("D_count", n_starts, 21);
        chk("D_seg", segment_num, 2);

        // E: busy high in IDLE blocks a burst
        resp_mode = 2;
        idle(2);
        enable = 1'b1;
        idle(40);
        chk("E_blocked", n_starts, 21);
        enable = 1'b0;
        idle(2);
        resp_mode = 1;
        idle(5);

        // F: asynchronous reset while waiting for the builder to finish
        gap_count = 28'd4;
        enable    = 1'b1;
        wait_starts(22, 200, "F_reach22");
        idle(3);
        chk("F_pre_busy", busy, 1);
        chk("F_pre_seg",  segment_num, 2);
        chk("F_pre_aux",  aux, 6);
        model_on = 0;
        #1;
        rstn = 1'b0;
        #1;
        chk("F_rst_start", start_sending, 0);
        chk("F_rst_txid",  txid, 0);
        chk("F_rst_seg",   segment_num, 0);
        chk("F_rst_aux",   aux, 0);
        chk("F_rst_drop",  drop_pulse, 0);
        resp_mode = 3;
        idle(3);
        rstn      = 1'b1;
        resp_mode = 1;
        wait_starts(23, 100, "F_reach23");
        enable = 1'b0;
        chk("F_post_seg",  qget(log_seg, 22), 0);
        chk("F_post_txid", qget(log_txid, 22), 0);
        chk("F_post_aux",  qget(log_aux, 22), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
